biu_bus_sequencer: RTL and testbench

Bus-interface sequencer that shares the GenDir address generator and the external memory bus between the instruction-fetch unit (IF) and the execution unit (EU). It arbitrates the two requesters and drives the GenDir controls (OP, SEG_SEL, M1_SEL, M2_SEL, DESP). It then registers the 20-bit DIR result as the bus address and runs a T1–T4 bus cycle with READY-driven wait states. Finally it returns read data with a one-cycle acknowledge.

---
 rtl/biu_bus_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_biu_bus_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_bus_sequencer.sv
// ---------------------------------------------------------------------------
// biu_bus_sequencer
//
// Bus-interface sequencer shared by the instruction-fetch unit (IF) and the
// execution unit (EU). It arbitrates the two requesters and drives the GenDir
// address-generator controls. It latches the GenDir DIR result as the bus
// address and runs a T1-T4 bus cycle with READY-driven wait states. Read data
// is returned with a one-cycle acknowledge.
//
// Parameters
//   TIMEOUT_CYC  maximum TW cycles before a forced T4. Only meaningful when
//                the BUS_TIMEOUT_EN macro is defined.
//
// Optional feature (macro BUS_TIMEOUT_EN)
//   defined   : a wait-state watchdog aborts the cycle after TIMEOUT_CYC TW
//               cycles. ACK then pulses with ERR=1, and reads return 16'hFFFF.
//   undefined : TW persists until READY=1, and ERR is tied low.
//
// Ports
//   CLK, RST          clock (rising edge); asynchronous active-high reset
//   IF_REQ / IF_ACK   fetch request (level) / done pulse (also the IP strobe)
//   EU_REQ / EU_ACK   data request (level) / done pulse
//   EU_WR             1 = write, 0 = read
//   EU_SEG_SEL, EU_M1_SEL, EU_M2_SEL, EU_DESP, EU_WDATA
//                     EU access descriptor, captured at grant
//   RDATA             read data, valid in the ACK cycle
//   GD_OP, GD_SEG_SEL, GD_M1_SEL, GD_M2_SEL, GD_DESP
//                     registered GenDir controls
//   GD_DIR            GenDir 20-bit result
//   ADDR, ALE, RD_N, WR_N, DOUT, DIN, READY
//                     external memory bus
//   BUSY              high whenever the sequencer is not idle
//   ERR               timeout flag, pulses together with ACK
// ---------------------------------------------------------------------------
module biu_bus_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_REQ,
    output logic        IF_ACK,
    input  logic        EU_REQ,
    input  logic        EU_WR,
    input  logic [1:0]  EU_SEG_SEL,
    input  logic [2:0]  EU_M1_SEL,
    input  logic [2:0]  EU_M2_SEL,
    input  logic [15:0] EU_DESP,
    input  logic [15:0] EU_WDATA,
    output logic        EU_ACK,
    output logic [15:0] RDATA,
    output logic        GD_OP,
    output logic [1:0]  GD_SEG_SEL,
    output logic [2:0]  GD_M1_SEL,
    output logic [2:0]  GD_M2_SEL,
    output logic [15:0] GD_DESP,
    input  logic [19:0] GD_DIR,
    output logic [19:0] ADDR,
    output logic        ALE,
    output logic        RD_N,
    output logic        WR_N,
    output logic [15:0] DOUT,
    input  logic [15:0] DIN,
    input  logic        READY,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_TW,
        S_T4
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_EU
    } owner_t;

    // GenDir selector code for the "zero" input
    localparam logic [2:0] SEL_ZERO = 3'd5;

    state_t      state;
    state_t      state_nx;
    // Current bus owner; it doubles as the last-grant record for round-robin.
    owner_t      owner;
    logic        wr_q;
    logic [15:0] wdata_q;

    logic        grant_if;
    logic        grant_eu;
    logic        strobe_phase;
    logic        abort;
    logic        cycle_end;

    // -----------------------------------------------------------------------
    // Arbitration. In T4 the requester being acknowledged still holds its
    // REQ, so only the other requester may be granted back-to-back.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_if = 1'b0;
        grant_eu = 1'b0;
        if (state == S_IDLE) begin
            if (IF_REQ && EU_REQ) begin
                if (owner == OWN_IF) begin
                    grant_eu = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else if (IF_REQ) begin
                grant_if = 1'b1;
            end else if (EU_REQ) begin
                grant_eu = 1'b1;
            end
        end else if (state == S_T4) begin
            if (owner == OWN_EU) begin
                grant_if = IF_REQ;
            end else begin
                grant_eu = EU_REQ;
            end
        end
    end

    assign strobe_phase = (state == S_T3) || (state == S_TW);
    // Last strobe cycle: READY accepted, or the watchdog expired
    assign cycle_end    = strobe_phase && (READY || abort);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (grant_if || grant_eu) begin
                    state_nx = S_T1;
                end
            end
            S_T1: state_nx = S_T2;
            S_T2: state_nx = S_T3;
            S_T3, S_TW: begin
                if (cycle_end) begin
                    state_nx = S_T4;
                end else begin
                    state_nx = S_TW;
                end
            end
            S_T4: begin
                if (grant_if || grant_eu) begin
                    state_nx = S_T1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register, grant capture, address / data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            owner      <= OWN_IF;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            GD_OP      <= 1'b0;
            GD_SEG_SEL <= '0;
            GD_M1_SEL  <= SEL_ZERO;
            GD_M2_SEL  <= SEL_ZERO;
            GD_DESP    <= '0;
            ADDR       <= '0;
            DOUT       <= '0;
            RDATA      <= '0;
        end else begin
            state <= state_nx;

            if (grant_if) begin
                owner      <= OWN_IF;
                wr_q       <= 1'b0;
                GD_OP      <= 1'b0;
                GD_SEG_SEL <= '0;
                GD_M1_SEL  <= SEL_ZERO;
                GD_M2_SEL  <= SEL_ZERO;
                GD_DESP    <= '0;
            end else if (grant_eu) begin
                owner      <= OWN_EU;
                wr_q       <= EU_WR;
                wdata_q    <= EU_WDATA;
                GD_OP      <= 1'b1;
                GD_SEG_SEL <= EU_SEG_SEL;
                GD_M1_SEL  <= EU_M1_SEL;
                GD_M2_SEL  <= EU_M2_SEL;
                GD_DESP    <= EU_DESP;
            end

            // GenDir has settled during T1
            if (state == S_T1) begin
                ADDR <= GD_DIR;
                if (wr_q) begin
                    DOUT <= wdata_q;
                end
            end

            if (cycle_end && !wr_q) begin
                RDATA <= abort ? 16'hFFFF : DIN;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Optional wait-state watchdog
    // -----------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] to_cnt;
    logic          err_q;

    // Fires in the TIMEOUT_CYC-th TW cycle; READY=1 in that cycle still wins.
    assign abort = (state == S_TW) && !READY
                   && (to_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_T2) begin
                to_cnt <= '0;
            end else if (state == S_TW) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (cycle_end) begin
                err_q <= abort;
            end
        end
    end

    assign ERR = (state == S_T4) && err_q;
`else
    assign abort = 1'b0;
    assign ERR   = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Bus strobes and handshakes, decoded from the state register
    // -----------------------------------------------------------------------
    assign BUSY   = (state != S_IDLE);
    assign ALE    = (state == S_T2);
    assign RD_N   = !(strobe_phase && !wr_q);
    assign WR_N   = !(strobe_phase && wr_q);
    assign IF_ACK = (state == S_T4) && (owner == OWN_IF);
    assign EU_ACK = (state == S_T4) && (owner == OWN_EU);

endmodule

// File: tb/tb_biu_bus_sequencer.sv
module tb_biu_bus_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IF_REQ;
    logic        IF_ACK;
    logic        EU_REQ;
    logic        EU_WR;
    logic [1:0]  EU_SEG_SEL;
    logic [2:0]  EU_M1_SEL;
    logic [2:0]  EU_M2_SEL;
    logic [15:0] EU_DESP;
    logic [15:0] EU_WDATA;
    logic        EU_ACK;
    logic [15:0] RDATA;
    logic        GD_OP;
    logic [1:0]  GD_SEG_SEL;
    logic [2:0]  GD_M1_SEL;
    logic [2:0]  GD_M2_SEL;
    logic [15:0] GD_DESP;
    logic [19:0] GD_DIR;
    logic [19:0] ADDR;
    logic        ALE;
    logic        RD_N;
    logic        WR_N;
    logic [15:0] DOUT;
    logic [15:0] DIN;
    logic        READY;
    logic        BUSY;
    logic        ERR;

    biu_bus_sequencer #(.TIMEOUT_CYC(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IF_REQ     (IF_REQ),
        .IF_ACK     (IF_ACK),
        .EU_REQ     (EU_REQ),
        .EU_WR      (EU_WR),
        .EU_SEG_SEL (EU_SEG_SEL),
        .EU_M1_SEL  (EU_M1_SEL),
        .EU_M2_SEL  (EU_M2_SEL),
        .EU_DESP    (EU_DESP),
        .EU_WDATA   (EU_WDATA),
        .EU_ACK     (EU_ACK),
        .RDATA      (RDATA),
        .GD_OP      (GD_OP),
        .GD_SEG_SEL (GD_SEG_SEL),
        .GD_M1_SEL  (GD_M1_SEL),
        .GD_M2_SEL  (GD_M2_SEL),
        .GD_DESP    (GD_DESP),
        .GD_DIR     (GD_DIR),
        .ADDR       (ADDR),
        .ALE        (ALE),
        .RD_N       (RD_N),
        .WR_N       (WR_N),
        .DOUT       (DOUT),
        .DIN        (DIN),
        .READY      (READY),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    // One bus transaction: stimulus plus hand-computed expectations.
    typedef struct {
        bit          is_eu;
        bit          wr;
        logic [1:0]  seg;
        logic [2:0]  m1;
        logic [2:0]  m2;
        logic [15:0] desp;
        logic [15:0] wdata;
        logic [19:0] dir;
        logic [15:0] din;
        int unsigned nwait;     // READY=0 samples in T3/TW
        bit          e_op;
        logic [1:0]  e_seg;
        logic [2:0]  e_m1;
        logic [2:0]  e_m2;
        logic [15:0] e_desp;
        logic [19:0] e_addr;
        logic [15:0] e_rdata;
        logic [15:0] e_dout;
        bit          e_err;
        int unsigned e_lat;     // edges from request to ACK
        int unsigned e_rd;      // cycles with RD_N low
        int unsigned e_wr;      // cycles with WR_N low
    } txn_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   32'(BUSY),       32'h0);
        check({tag, "_ale"},    32'(ALE),        32'h0);
        check({tag, "_rd_n"},   32'(RD_N),       32'h1);
        check({tag, "_wr_n"},   32'(WR_N),       32'h1);
        check({tag, "_if_ack"}, 32'(IF_ACK),     32'h0);
        check({tag, "_eu_ack"}, 32'(EU_ACK),     32'h0);
        check({tag, "_err"},    32'(ERR),        32'h0);
        check({tag, "_addr"},   32'(ADDR),       32'h0);
        check({tag, "_dout"},   32'(DOUT),       32'h0);
        check({tag, "_rdata"},  32'(RDATA),      32'h0);
        check({tag, "_gd_op"},  32'(GD_OP),      32'h0);
        check({tag, "_gd_seg"}, 32'(GD_SEG_SEL), 32'h0);
        check({tag, "_gd_m1"},  32'(GD_M1_SEL),  32'h5);
        check({tag, "_gd_m2"},  32'(GD_M2_SEL),  32'h5);
        check({tag, "_gd_desp"},32'(GD_DESP),    32'h0);
    endtask

    // Called shortly after a rising edge with the sequencer idle; returns
    // shortly after the edge following the ACK cycle.
    task automatic run_txn(input txn_t t, input string tag);
        int unsigned rd_cnt = 0;
        int unsigned wr_cnt = 0;
        int unsigned ack_cyc = 0;
        int unsigned waits_left;
        bit          acked = 1'b0;
        EU_WR      = t.wr;
        EU_SEG_SEL = t.seg;
        EU_M1_SEL  = t.m1;
        EU_M2_SEL  = t.m2;
        EU_DESP    = t.desp;
        EU_WDATA   = t.wdata;
        GD_DIR     = t.dir;
        DIN        = t.din;
        READY      = 1'b1;
        waits_left = t.nwait;
        if (t.is_eu) EU_REQ = 1'b1;
        else         IF_REQ = 1'b1;
        for (int unsigned cyc = 1; cyc <= 40 && !acked; cyc++) begin
            @(posedge CLK);
            #1;
            if (cyc == 1) begin
                check({tag, "_t1_busy"}, 32'(BUSY),       32'h1);
                check({tag, "_t1_ale"},  32'(ALE),        32'h0);
                check({tag, "_gd_op"},   32'(GD_OP),      32'(t.e_op));
                check({tag, "_gd_seg"},  32'(GD_SEG_SEL), 32'(t.e_seg));
                check({tag, "_gd_m1"},   32'(GD_M1_SEL),  32'(t.e_m1));
                check({tag, "_gd_m2"},   32'(GD_M2_SEL),  32'(t.e_m2));
                check({tag, "_gd_desp"}, 32'(GD_DESP),    32'(t.e_desp));
            end
            if (cyc == 2) begin
                check({tag, "_t2_ale"},  32'(ALE),  32'h1);
                check({tag, "_t2_addr"}, 32'(ADDR), 32'(t.e_addr));
                GD_DIR = ~t.dir;   // ADDR must stay latched from here on
            end
            if (cyc == 3) check({tag, "_t3_ale"}, 32'(ALE), 32'h0);
            if (!RD_N) rd_cnt++;
            if (!WR_N) wr_cnt++;
            if ((!RD_N || !WR_N) && waits_left > 0) begin
                READY = 1'b0;
                waits_left--;
            end else begin
                READY = 1'b1;
            end
            if (IF_ACK || EU_ACK) begin
                acked   = 1'b1;
                ack_cyc = cyc;
                check({tag, "_own_ack"},   32'(t.is_eu ? EU_ACK : IF_ACK), 32'h1);
                check({tag, "_other_ack"}, 32'(t.is_eu ? IF_ACK : EU_ACK), 32'h0);
                check({tag, "_rdata"},     32'(RDATA), 32'(t.e_rdata));
                check({tag, "_dout"},      32'(DOUT),  32'(t.e_dout));
                check({tag, "_addr_held"}, 32'(ADDR),  32'(t.e_addr));
                check({tag, "_err"},       32'(ERR),   32'(t.e_err));
                check({tag, "_t4_strobe"}, 32'({RD_N, WR_N, ALE}), 32'b110);
                EU_REQ = 1'b0;
                IF_REQ = 1'b0;
            end
        end
        check({tag, "_ack_seen"}, 32'(acked), 32'h1);
        EU_REQ = 1'b0;
        IF_REQ = 1'b0;
        READY  = 1'b1;
        check({tag, "_ack_latency"}, ack_cyc, t.e_lat);
        check({tag, "_rd_cycles"},   rd_cnt,  t.e_rd);
        check({tag, "_wr_cycles"},   wr_cnt,  t.e_wr);
        @(posedge CLK);
        #1;
        check({tag, "_ack_pulse"}, 32'({IF_ACK, EU_ACK}), 32'h0);
        check({tag, "_idle_busy"}, 32'(BUSY),             32'h0);
        check({tag, "_idle_err"},  32'(ERR),              32'h0);
    endtask

    txn_t tv [5];
    txn_t tr;

    initial begin
        // is_eu wr seg m1 m2 desp wdata dir din nwait |
        // e_op e_seg e_m1 e_m2 e_desp e_addr e_rdata e_dout e_err e_lat e_rd e_wr
        tv[0] = '{1'b1, 1'b0, 2'd1, 3'd0, 3'd5, 16'h0010, 16'h0000, 20'h12350, 16'hBEEF, 0,
                  1'b1, 2'd1, 3'd0, 3'd5, 16'h0010, 20'h12350, 16'hBEEF, 16'h0000, 1'b0, 4, 1, 0};
        // IF fetch with conflicting EU inputs that must be ignored
        tv[1] = '{1'b0, 1'b1, 2'd3, 3'd1, 3'd2, 16'h1111, 16'h7777, 20'h0ABCD, 16'h1234, 0,
                  1'b0, 2'd0, 3'd5, 3'd5, 16'h0000, 20'h0ABCD, 16'h1234, 16'h0000, 1'b0, 4, 1, 0};
        // EU write, 3 wait states; RDATA keeps the previous read value
        tv[2] = '{1'b1, 1'b1, 2'd2, 3'd3, 3'd6, 16'h8000, 16'hA55A, 20'hFFFFF, 16'h5A5A, 3,
                  1'b1, 2'd2, 3'd3, 3'd6, 16'h8000, 20'hFFFFF, 16'h1234, 16'hA55A, 1'b0, 7, 0, 4};
        // EU read, 1 wait state; DOUT keeps the last write data
        tv[3] = '{1'b1, 1'b0, 2'd3, 3'd7, 3'd2, 16'hFFFF, 16'h0F0F, 20'h00001, 16'h0000, 1,
                  1'b1, 2'd3, 3'd7, 3'd2, 16'hFFFF, 20'h00001, 16'h0000, 16'hA55A, 1'b0, 5, 2, 0};
        // IF fetch, 2 wait states
        tv[4] = '{1'b0, 1'b0, 2'd1, 3'd4, 3'd4, 16'h0042, 16'h3C3C, 20'h80000, 16'hC3C3, 2,
                  1'b0, 2'd0, 3'd5, 3'd5, 16'h0000, 20'h80000, 16'hC3C3, 16'hA55A, 1'b0, 6, 3, 0};

        RST = 1'b1;
        IF_REQ = 1'b0; EU_REQ = 1'b0; EU_WR = 1'b0;
        EU_SEG_SEL = '0; EU_M1_SEL = '0; EU_M2_SEL = '0;
        EU_DESP = '0; EU_WDATA = '0; GD_DIR = '0; DIN = '0; READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_vals("por");
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("idle_no_req", 32'(BUSY), 32'h0);

        for (int i = 0; i < 5; i++) begin
            run_txn(tv[i], $sformatf("vec%0d", i));
        end

        // Both requesters held after reset: EU, IF, EU, IF back-to-back.
        begin
            int unsigned ack_n = 0;
            int unsigned idle_cnt = 0;
            RST = 1'b1;
            @(posedge CLK);
            #1;
            RST = 1'b0;
            EU_WR = 1'b0; EU_SEG_SEL = 2'd2; EU_M1_SEL = 3'd1; EU_M2_SEL = 3'd3;
            EU_DESP = 16'h0020; GD_DIR = 20'h54321; DIN = 16'h00AA; READY = 1'b1;
            IF_REQ = 1'b1;
            EU_REQ = 1'b1;
            for (int unsigned cyc = 1; cyc <= 24 && ack_n < 4; cyc++) begin
                @(posedge CLK);
                #1;
                if (!BUSY) idle_cnt++;
                if (cyc % 4 == 1)
                    check($sformatf("tie_grant%0d_op", ack_n), 32'(GD_OP), 32'(ack_n % 2 == 0));
                if (IF_ACK || EU_ACK) begin
                    check($sformatf("tie_ack%0d_cycle", ack_n), cyc, 4 * (ack_n + 1));
                    check($sformatf("tie_ack%0d_is_eu", ack_n), 32'(EU_ACK), 32'(ack_n % 2 == 0));
                    ack_n++;
                    if (ack_n == 4) begin
                        IF_REQ = 1'b0;
                        EU_REQ = 1'b0;
                    end
                end
            end
            IF_REQ = 1'b0;
            EU_REQ = 1'b0;
            check("tie_ack_count", ack_n, 4);
            check("tie_no_idle_gap", idle_cnt, 0);
            @(posedge CLK);
            #1;
            check("tie_end_busy", 32'(BUSY), 32'h0);
        end

        // Reset asserted while in TW: asynchronous abort, then restart at T1.
        EU_WR = 1'b0; EU_SEG_SEL = 2'd1; EU_M1_SEL = 3'd2; EU_M2_SEL = 3'd3;
        EU_DESP = 16'h0004; GD_DIR = 20'h2468A; DIN = 16'h9999;
        READY  = 1'b0;
        EU_REQ = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("tw_rd_low", 32'(RD_N), 32'h0);
        #2;
        RST = 1'b1;
        #1;
        check_reset_vals("tw_rst");
        repeat (2) begin
            @(posedge CLK);
            #1;
            check("tw_rst_no_ack", 32'({IF_ACK, EU_ACK}), 32'h0);
            check("tw_rst_busy",   32'(BUSY),             32'h0);
        end
        @(negedge CLK);
        RST   = 1'b0;
        READY = 1'b1;
        tr = '{1'b1, 1'b0, 2'd1, 3'd2, 3'd3, 16'h0004, 16'h0000, 20'h2468A, 16'h9999, 0,
               1'b1, 2'd1, 3'd2, 3'd3, 16'h0004, 20'h2468A, 16'h9999, 16'h0000, 1'b0, 4, 1, 0};
        run_txn(tr, "restart");

        // READY held low: watchdog abort, or indefinite wait states.
`ifdef BUS_TIMEOUT_EN
        tr = '{1'b1, 1'b0, 2'd0, 3'd1, 3'd5, 16'h0100, 16'h0000, 20'h30000, 16'h1357, 99,
               1'b1, 2'd0, 3'd1, 3'd5, 16'h0100, 20'h30000, 16'hFFFF, 16'h0000, 1'b1, 20, 17, 0};
        run_txn(tr, "timeout");
        tr = '{1'b1, 1'b0, 2'd0, 3'd1, 3'd5, 16'h0100, 16'h0000, 20'h30000, 16'h2468, 0,
               1'b1, 2'd0, 3'd1, 3'd5, 16'h0100, 20'h30000, 16'h2468, 16'h0000, 1'b0, 4, 1, 0};
        run_txn(tr, "after_timeout");
`else
        tr = '{1'b1, 1'b0, 2'd0, 3'd1, 3'd5, 16'h0100, 16'h0000, 20'h30000, 16'h1357, 20,
               1'b1, 2'd0, 3'd1, 3'd5, 16'h0100, 20'h30000, 16'h1357, 16'h0000, 1'b0, 24, 21, 0};
        run_txn(tr, "long_wait");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
